// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// ready handshakes; outputs decode from state plus latched instruction fields.
module multicycle_control_unit #(
    parameter bit MUL_EN          = 1'b0,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       i_ready,
    input  logic       dm_ready,
    input  logic       alu_done,
    output logic       IMRd,
    output logic       IRWr,
    output logic       PCWr,
    output logic       PCWrCond,
    output logic [2:0] BrOp,
    output logic       RUWr,
    output logic [2:0] IMMSrc,
    output logic [1:0] ALUASrc,
    output logic       ALUBSrc,
    output logic [4:0] ALUop,
    output logic       ALUStart,
    output logic       DMRd,
    output logic       DMWR,
    output logic [2:0] DMCtrl,
    output logic [1:0] RUDataWrSrc,
    output logic       illegal,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_TRAP   = 3'b110
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic [2:0] f3_q, f3_d;
    logic [6:0] f7_q, f7_d;
    logic       mwait_q, mwait_d;

    logic is_op, is_opi, is_ld, is_st, is_br;
    logic is_jal, is_jalr, is_lui, is_auipc, is_m, legal;

    always_comb begin
        is_op    = (op_q == 7'b0110011);
        is_opi   = (op_q == 7'b0010011);
        is_ld    = (op_q == 7'b0000011);
        is_st    = (op_q == 7'b0100011);
        is_br    = (op_q == 7'b1100011);
        is_jal   = (op_q == 7'b1101111);
        is_jalr  = (op_q == 7'b1100111);
        is_lui   = (op_q == 7'b0110111);
        is_auipc = (op_q == 7'b0010111);
        is_m     = MUL_EN && is_op && (f7_q == 7'b0000001);
        legal    = 1'b0;
        if (is_op) begin
            legal = (f7_q == 7'b0000000) || is_m ||
                    ((f7_q == 7'b0100000) &&
                     ((f3_q == 3'b000) || (f3_q == 3'b101)));
        end else if (is_opi) begin
            if (f3_q == 3'b001)
                legal = (f7_q == 7'b0000000);
            else if (f3_q == 3'b101)
                legal = (f7_q == 7'b0000000) || (f7_q == 7'b0100000);
            else
                legal = 1'b1;
        end else if (is_ld) begin
            legal = !((f3_q == 3'b011) || (f3_q[2:1] == 2'b11));
        end else if (is_st) begin
            legal = (f3_q <= 3'b010);
        end else begin
            legal = is_br || is_jal || is_jalr || is_lui || is_auipc;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        f3_d    = f3_q;
        f7_d    = f7_q;
        mwait_d = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (i_ready) begin
                    state_d = S_DECODE;
                    op_d    = opcode;
                    f3_d    = funct3;
                    f7_d    = funct7;
                end
            end
            S_DECODE: begin
                if (legal)
                    state_d = S_EXEC;
                else
                    state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            S_EXEC: begin
                // mwait_q marks that the start pulse has already been issued
                if (is_m) begin
                    mwait_d = 1'b1;
                    if (alu_done)
                        state_d = S_WB;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_br) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dm_ready)
                    state_d = is_ld ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 7'd0;
            f3_q    <= 3'd0;
            f7_q    <= 7'd0;
            mwait_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            f7_q    <= f7_d;
            mwait_q <= mwait_d;
        end
    end

    always_comb begin
        IMRd        = 1'b0;
        IRWr        = 1'b0;
        PCWr        = 1'b0;
        PCWrCond    = 1'b0;
        BrOp        = 3'b000;
        RUWr        = 1'b0;
        IMMSrc      = 3'b000;
        ALUASrc     = 2'b00;
        ALUBSrc     = 1'b0;
        ALUop       = 5'b00000;
        ALUStart    = 1'b0;
        DMRd        = 1'b0;
        DMWR        = 1'b0;
        DMCtrl      = 3'b000;
        RUDataWrSrc = 2'b00;
        case (state_q)
            S_FETCH: begin
                IMRd = 1'b1;
                IRWr = i_ready;
                PCWr = i_ready;
            end
            S_EXEC: begin
                if (is_op) begin
                    ALUop    = is_m ? {2'b10, f3_q} : {1'b0, f7_q[5], f3_q};
                    ALUStart = is_m && !mwait_q;
                end else if (is_opi) begin
                    ALUBSrc = 1'b1;
                    ALUop   = {1'b0, (f3_q == 3'b101) && f7_q[5], f3_q};
                end else if (is_ld || is_st) begin
                    ALUBSrc = 1'b1;
                    IMMSrc  = is_ld ? 3'b001 : 3'b010;
                end else if (is_br) begin
                    ALUop    = 5'b01000;
                    IMMSrc   = 3'b011;
                    PCWrCond = 1'b1;
                    BrOp     = f3_q;
                end else if (is_jal) begin
                    PCWr    = 1'b1;
                    ALUASrc = 2'b01;
                    ALUBSrc = 1'b1;
                    IMMSrc  = 3'b101;
                end else if (is_jalr) begin
                    PCWr    = 1'b1;
                    ALUBSrc = 1'b1;
                end else if (is_lui || is_auipc) begin
                    ALUASrc = is_lui ? 2'b10 : 2'b01;
                    ALUBSrc = 1'b1;
                    IMMSrc  = 3'b100;
                end
            end
            S_MEM: begin
                DMRd   = is_ld;
                DMWR   = is_st;
                DMCtrl = f3_q;
            end
            S_WB: begin
                RUWr = 1'b1;
                if (is_ld)
                    RUDataWrSrc = 2'b01;
                else if (is_jal || is_jalr)
                    RUDataWrSrc = 2'b10;
            end
            default: ;
        endcase
    end

    assign illegal = (state_q == S_TRAP);
    assign state   = state_q;
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle RV32I control FSM, the next generation of the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on ready handshakes from instruction memory, data memory and an optional multi-cycle M-extension ALU. It latches the instruction fields itself and drives every datapath enable and mux select, including PC and IR write strobes. It keeps the existing ALUop, IMMSrc, DMCtrl and RUDataWrSrc encodings.

## Interface
- MUL_EN, 0: 1 decodes funct7=0000001 on OP as M-extension; 0 treats it as illegal.
- TRAP_ON_ILLEGAL, 1: 1 makes an illegal instruction enter TRAP; 0 retires it as a NOP.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  instruction memory read data [6:0].
- funct3  in  3  instruction [14:12].
- funct7  in  7  instruction [31:25].
- i_ready  in  1  instruction memory read data valid.
- dm_ready  in  1  data memory access complete.
- alu_done  in  1  multi-cycle ALU result valid; ignored when MUL_EN=0.
- IMRd  out  1  instruction fetch request.
- IRWr, PCWr  out  1  IR and PC write strobes.
- PCWrCond  out  1  PC write qualified by branch-taken in the datapath.
- BrOp  out  3  branch condition (funct3).
- RUWr  out  1  register file write.
- IMMSrc  out  3  immediate format: I=000, load=001, S=010, B=011, U=100, J=101.
- ALUASrc  out  2  ALU A select: 00 rs1, 01 PC, 10 zero.
- ALUBSrc  out  1  ALU B select: 0 rs2, 1 immediate.
- ALUop  out  5  bit4 marks an M op, with [2:0]=funct3 and [3]=0. Otherwise: add 00000, sll 00001, slt 00010, sltu 00011, xor 00100, srl 00101, or 00110, and 00111, sub 01000, sra 01101.
- ALUStart  out  1  one-cycle start pulse to the multi-cycle ALU.
- DMRd, DMWR  out  1  data memory read and write.
- DMCtrl  out  3  access size/sign (funct3).
- RUDataWrSrc  out  2  writeback source: 00 ALU, 01 DM, 10 PC+4.
- illegal  out  1  high while in TRAP.
- state  out  3  encoded state: IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, TRAP 110.

## Operation
- **Reset.** Reset forces IDLE and clears the latched fields. All outputs are 0 in IDLE.
- **IDLE.** Goes unconditionally to FETCH.
- **FETCH.**
  - Asserts IMRd.
  - When i_ready=1: asserts IRWr and PCWr (PC+4), latches opcode/funct3/funct7, and moves to DECODE. Otherwise it holds.
- **DECODE.**
  - Classifies the latched opcode: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Illegal means: any other opcode; OP with an undefined {funct7,funct3}; OP-IMM slli/srli/srai with a bad funct7; LOAD funct3 ∈ {011,110,111}; STORE funct3 > 010.
  - Illegal goes to TRAP if TRAP_ON_ILLEGAL=1, else to FETCH. Legal goes to EXEC.
- **EXEC.**
  - OP: ALUBSrc=0 and ALUop from {funct7,funct3}. OP-IMM: ALUBSrc=1, IMMSrc=000, and funct3=101 with funct7[5]=1 gives sra. OP/OP-IMM then go to WB.
  - LOAD/STORE: ALUop add, ALUBSrc=1, IMMSrc 001 (LOAD) or 010 (STORE), then MEM.
  - BRANCH: ALUop sub, IMMSrc=011, PCWrCond=1, BrOp=funct3, then FETCH.
  - JAL/JALR: PCWr=1 (JAL: ALUASrc=01, IMMSrc=101; JALR: rs1+I-immediate, IMMSrc=000), then WB.
  - LUI: ALUASrc=10, IMMSrc=100. AUIPC: ALUASrc=01, IMMSrc=100. Both then WB.
  - M op: ALUStart pulses on the first EXEC cycle only. EXEC holds until alu_done=1, then WB.
- **MEM.** DMCtrl=funct3 and DMRd/DMWR are held until dm_ready=1. Then LOAD goes to WB and STORE to FETCH.
- **WB.**
  - RUWr=1, then FETCH.
  - RUDataWrSrc is 01 for LOAD, 10 for JAL/JALR, otherwise 00.
  - Writes to x0 are the register file's concern.
- **TRAP.** Holds until reset, with illegal=1 and all other outputs 0.
- **Unlisted outputs.** Any output not listed for a state is 0.

## Timing
- **Latency** (cycles from FETCH entry, i_ready=dm_ready=1 on the first request cycle):
  - BRANCH 3.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE 4.
  - LOAD 5.
  - M op: 4 + cycles until alu_done.
- **Output decode.** Outputs are combinational from state plus latched fields. IRWr/PCWr in FETCH are additionally gated by i_ready.
- **Handshake waits.** Each wait adds one cycle per deasserted ready cycle. Control outputs stay stable throughout the wait.
- **Ready inputs.** i_ready is ignored outside FETCH and dm_ready outside MEM. A ready input seen in a non-waiting state is not remembered.
- **Reset mid-instruction.** Reset in any state returns to IDLE on the next edge, with no memory or register side effects after that edge.

## Test plan
- **Reset, then add.** Reset, then add x3,x1,x2 ({0000000,000}, opcode 0110011) with i_ready=1.
  - States IDLE, FETCH, DECODE, EXEC, WB, FETCH.
  - In EXEC: ALUop=00000, ALUBSrc=0.
  - In WB: RUWr=1, RUDataWrSrc=00.
- **Stalled lw.**
  - Stimulus: lw (0000011, funct3 010) with i_ready low for 2 cycles and dm_ready low for 3 cycles.
  - Response: FETCH lasts 3 cycles and MEM lasts 4 cycles, with DMRd=1 and DMCtrl=010 held throughout MEM. WB has RUDataWrSrc=01. Total 10 cycles.
- **sw then beq.**
  - sw (0100011, funct3 010) has DMWR=1 in MEM, RUWr=0 in every state, and is 4 cycles.
  - beq (1100011) has PCWrCond=1, ALUop=01000, BrOp=000 in EXEC, and is 3 cycles.
- **srai and jal.**
  - srai (OP-IMM, funct3 101, funct7 0100000) gives ALUop=01101.
  - jal gives PCWr=1 and IMMSrc=101 in EXEC, and RUDataWrSrc=10 in WB.
- **MUL_EN=1, mul.** mul ({0000001,000}) with alu_done arriving 5 cycles after EXEC entry: ALUStart is high for exactly 1 cycle, ALUop=10000, and EXEC lasts 6 cycles.
- **Illegal opcode.**
  - Stimulus: opcode 1111111.
  - TRAP_ON_ILLEGAL=1: TRAP is entered after DECODE with illegal=1, and stays there until rst_n=0 is applied mid-TRAP, which returns to IDLE.
  - TRAP_ON_ILLEGAL=0: DECODE goes to FETCH, with RUWr and DMWR never asserted.
